// File: rtl/i2s_receiver.sv
// I2S / left-justified serial audio receiver with oversampled SCK and word-select edge detection.
// Optional I2S_RX_MONO_EN adds a registered mono output, the average of the left and right samples.
module i2s_receiver #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned FORMAT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ck,
  input  logic             lr,
  input  logic             d,
  output logic [WIDTH-1:0] lmidi,
  output logic [WIDTH-1:0] rmidi,
  output logic             lvalid,
  output logic             rvalid,
  output logic             pvalid,
  output logic             short
`ifdef I2S_RX_MONO_EN
  ,
  output logic [WIDTH-1:0] mono
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StSync, StRun} state_e;

  state_e          state_q;
  logic            ck_meta, ck_sync, ck_prev;
  logic            lr_meta, lr_sync, lr_prev;
  logic            d_meta, d_sync;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]   cnt_q;
  logic            left_seen_q;

  logic            sck_edge, ws_edge, word_full;
  logic [WIDTH-1:0] bit_pos;
  logic [WIDTH-1:0] first_word;

  always_comb begin
    sck_edge   = ck_sync & ~ck_prev;
    ws_edge    = sck_edge & (lr_sync != lr_prev);
    word_full  = (cnt_q == CW'(WIDTH));
    first_word = '0;
    first_word[WIDTH-1] = d_sync;
    // Bit k of the word lands at position WIDTH-1-k, so short words come out left-aligned.
    bit_pos = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (cnt_q == CW'(int'(WIDTH) - 1 - i)) bit_pos[i] = d_sync;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StSync;
      ck_meta     <= 1'b0;
      ck_sync     <= 1'b0;
      ck_prev     <= 1'b0;
      lr_meta     <= 1'b0;
      lr_sync     <= 1'b0;
      lr_prev     <= 1'b0;
      d_meta      <= 1'b0;
      d_sync      <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      left_seen_q <= 1'b0;
      lmidi       <= '0;
      rmidi       <= '0;
      lvalid      <= 1'b0;
      rvalid      <= 1'b0;
      pvalid      <= 1'b0;
      short       <= 1'b0;
    end else begin
      ck_meta <= ck;
      ck_sync <= ck_meta;
      ck_prev <= ck_sync;
      lr_meta <= lr;
      lr_sync <= lr_meta;
      d_meta  <= d;
      d_sync  <= d_meta;
      lvalid  <= 1'b0;
      rvalid  <= 1'b0;
      pvalid  <= 1'b0;
      short   <= 1'b0;
      if (sck_edge) begin
        lr_prev <= lr_sync;
        if (ws_edge) begin
          if (state_q == StRun) begin
            if (!lr_prev) begin
              lmidi       <= sr_q;
              lvalid      <= 1'b1;
              left_seen_q <= 1'b1;
            end else begin
              rmidi       <= sr_q;
              rvalid      <= 1'b1;
              pvalid      <= left_seen_q;
              left_seen_q <= 1'b0;
            end
            short <= ~word_full;
          end
          state_q <= StRun;
          // Left-justified: the WS-edge bit is already the new MSB.
          if (FORMAT == 1) begin
            sr_q  <= first_word;
            cnt_q <= CW'(1);
          end else begin
            sr_q  <= '0;
            cnt_q <= '0;
          end
        end else if (!word_full) begin
          sr_q  <= sr_q | bit_pos;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

`ifdef I2S_RX_MONO_EN
  logic [WIDTH:0] mono_sum;

  assign mono_sum = {lmidi[WIDTH-1], lmidi} + {rmidi[WIDTH-1], rmidi};

  always_ff @(posedge clock) begin
    if (reset) begin
      mono <= '0;
    end else if (pvalid) begin
      mono <= mono_sum[WIDTH:1];
    end
  end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: three instances (16/F0, 24/F1, 24/F0) share one serial stream.
`timescale 1ns/1ps
module tb_i2s_receiver;

  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ck  = 1'b0;
  logic lr  = 1'b0;
  logic d   = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] l16, r16;
  logic [23:0] l24a, r24a, l24b, r24b;
  logic [2:0]  lv_w, rv_w, pv_w, sh_w;
  logic [2:0]  lv_p = '0, rv_p = '0, pv_p = '0;
`ifdef I2S_RX_MONO_EN
  logic [15:0] mono16;
  logic [23:0] mono24a, mono24b;
`endif

  int checks = 0;
  int errors = 0;
  int lv_n[3] = '{0, 0, 0};
  int rv_n[3] = '{0, 0, 0};
  int pv_n[3] = '{0, 0, 0};
  int sh_n[3] = '{0, 0, 0};
  int bad_n = 0;

  i2s_receiver #(.WIDTH(16), .FORMAT(0)) u16 (
    .clock(clk), .reset(rst), .ck(ck), .lr(lr), .d(d), .lmidi(l16), .rmidi(r16),
    .lvalid(lv_w[0]), .rvalid(rv_w[0]), .pvalid(pv_w[0]), .short(sh_w[0])
`ifdef I2S_RX_MONO_EN
    , .mono(mono16)
`endif
  );

  i2s_receiver #(.WIDTH(24), .FORMAT(1)) u24a (
    .clock(clk), .reset(rst), .ck(ck), .lr(lr), .d(d), .lmidi(l24a), .rmidi(r24a),
    .lvalid(lv_w[1]), .rvalid(rv_w[1]), .pvalid(pv_w[1]), .short(sh_w[1])
`ifdef I2S_RX_MONO_EN
    , .mono(mono24a)
`endif
  );

  i2s_receiver #(.WIDTH(24), .FORMAT(0)) u24b (
    .clock(clk), .reset(rst), .ck(ck), .lr(lr), .d(d), .lmidi(l24b), .rmidi(r24b),
    .lvalid(lv_w[2]), .rvalid(rv_w[2]), .pvalid(pv_w[2]), .short(sh_w[2])
`ifdef I2S_RX_MONO_EN
    , .mono(mono24b)
`endif
  );

  // Strobe counters plus a tally of strobes wider than one clock or out of step with each other.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lv_w[i]) lv_n[i] <= lv_n[i] + 1;
      if (rv_w[i]) rv_n[i] <= rv_n[i] + 1;
      if (pv_w[i]) pv_n[i] <= pv_n[i] + 1;
      if (sh_w[i]) sh_n[i] <= sh_n[i] + 1;
    end
    if (((lv_w & lv_p) | (rv_w & rv_p) | (pv_w & pv_p)) != 3'b000 ||
        (sh_w & ~(lv_w | rv_w)) != 3'b000 || (pv_w & ~rv_w) != 3'b000)
      bad_n <= bad_n + 1;
    lv_p <= lv_w;
    rv_p <= rv_w;
    pv_p <= pv_w;
  end

  task automatic do_reset();
    ck  = 1'b0;
    lr  = 1'b0;
    d   = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // One channel slot of slen SCKs. Format 0 puts a 1 in the leading delay bit so a failure to
  // discard it corrupts the word.
  task automatic send_slot(input logic lrv, input logic [31:0] word, input int nbits,
                           input int slen, input int fmt, input int stop_at);
    logic b;
    int   p;
    for (int k = 0; k < slen && k < stop_at; k++) begin
      p = (fmt == 0) ? k - 1 : k;
      if (fmt == 0 && k == 0) b = 1'b1;
      else if (p < nbits) b = word[nbits-1-p];
      else b = 1'b0;
      lr = lrv;
      d  = b;
      #(HALF);
      ck = 1'b1;
      #(HALF);
      ck = 1'b0;
    end
  endtask

  task automatic slot(input logic lrv, input logic [31:0] word, input int nbits, input int slen,
                      input int fmt);
    send_slot(lrv, word, nbits, slen, fmt, 1000);
  endtask

  // A single SCK with the new lr level, forcing the pending word to latch.
  task automatic flush(input logic lrv, input int fmt);
    send_slot(lrv, 32'h0, 0, 1, fmt, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    ck  = 1'b0;
    lr  = 1'b0;
    d   = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (l16 !== 16'h0) begin errors++; $display("FAIL reset_l16: got %h want 0", l16); end
    checks++; if (r16 !== 16'h0) begin errors++; $display("FAIL reset_r16: got %h want 0", r16); end
    checks++; if (l24b !== 24'h0) begin errors++; $display("FAIL reset_l24: got %h want 0", l24b); end
    checks++;
    if ({lv_w, rv_w, pv_w, sh_w} !== 12'h0) begin
      errors++; $display("FAIL reset_strobes: got %h want 000", {lv_w, rv_w, pv_w, sh_w});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int lv0, rv0, pv0, sh0;
    do_reset();
    slot(1'b0, 32'h0, 16, 32, 0);
    slot(1'b1, 32'h0, 16, 32, 0);
    lv0 = lv_n[0]; rv0 = rv_n[0]; pv0 = pv_n[0]; sh0 = sh_n[0];
    slot(1'b0, 32'h1234, 16, 32, 0);
    slot(1'b1, 32'hABCD, 16, 32, 0);
    flush(1'b0, 0);
    checks++; if (l16 !== 16'h1234) begin errors++; $display("FAIL basic_l: got %h want 1234", l16); end
    checks++; if (r16 !== 16'hABCD) begin errors++; $display("FAIL basic_r: got %h want abcd", r16); end
    checks++; if (lv_n[0] - lv0 != 1) begin errors++; $display("FAIL basic_lv: got %0d want 1", lv_n[0] - lv0); end
    checks++; if (rv_n[0] - rv0 != 2) begin errors++; $display("FAIL basic_rv: got %0d want 2", rv_n[0] - rv0); end
    checks++; if (pv_n[0] - pv0 != 1) begin errors++; $display("FAIL basic_pv: got %0d want 1", pv_n[0] - pv0); end
    checks++; if (sh_n[0] - sh0 != 0) begin errors++; $display("FAIL basic_short: got %0d want 0", sh_n[0] - sh0); end
  endtask

  task automatic test_format1();
    int lv0, sh0;
    do_reset();
    slot(1'b0, 32'h0, 24, 24, 1);
    slot(1'b1, 32'h0, 24, 24, 1);
    lv0 = lv_n[1]; sh0 = sh_n[1];
    slot(1'b0, 32'h800001, 24, 24, 1);
    slot(1'b1, 32'h123456, 24, 24, 1);
    flush(1'b0, 1);
    checks++; if (l24a !== 24'h800001) begin errors++; $display("FAIL lj_l: got %h want 800001", l24a); end
    checks++; if (r24a !== 24'h123456) begin errors++; $display("FAIL lj_r: got %h want 123456", r24a); end
    checks++; if (lv_n[1] - lv0 != 1) begin errors++; $display("FAIL lj_lv: got %0d want 1", lv_n[1] - lv0); end
    checks++; if (sh_n[1] - sh0 != 0) begin errors++; $display("FAIL lj_short: got %0d want 0", sh_n[1] - sh0); end
  endtask

  task automatic test_short_word();
    int lv0, rv0, sh0;
    do_reset();
    slot(1'b0, 32'h0, 16, 17, 0);
    slot(1'b1, 32'h0, 16, 17, 0);
    slot(1'b0, 32'h7FFF, 16, 17, 0);
    lv0 = lv_n[2]; rv0 = rv_n[2]; sh0 = sh_n[2];
    slot(1'b1, 32'h8001, 16, 17, 0);
    flush(1'b0, 0);
    checks++; if (l24b !== 24'h7FFF00) begin errors++; $display("FAIL short_l: got %h want 7fff00", l24b); end
    checks++; if (r24b !== 24'h800100) begin errors++; $display("FAIL short_r: got %h want 800100", r24b); end
    checks++; if (sh_n[2] - sh0 != 2) begin errors++; $display("FAIL short_cnt: got %0d want 2", sh_n[2] - sh0); end
    checks++; if (lv_n[2] - lv0 != 1) begin errors++; $display("FAIL short_lv: got %0d want 1", lv_n[2] - lv0); end
    checks++; if (rv_n[2] - rv0 != 1) begin errors++; $display("FAIL short_rv: got %0d want 1", rv_n[2] - rv0); end
  endtask

  task automatic test_zero_trunc();
    int sh0, rv0;
    do_reset();
    slot(1'b0, 32'h0, 16, 32, 0);
    slot(1'b1, 32'hFFFF, 16, 32, 0);
    slot(1'b0, 32'h5A5A5, 20, 32, 0);
    sh0 = sh_n[0]; rv0 = rv_n[0];
    slot(1'b1, 32'h0, 0, 1, 0);
    flush(1'b0, 0);
    checks++; if (l16 !== 16'h5A5A) begin errors++; $display("FAIL trunc_l: got %h want 5a5a", l16); end
    checks++; if (r16 !== 16'h0) begin errors++; $display("FAIL zero_r: got %h want 0000", r16); end
    checks++; if (sh_n[0] - sh0 != 1) begin errors++; $display("FAIL zero_short: got %0d want 1", sh_n[0] - sh0); end
    checks++; if (rv_n[0] - rv0 != 1) begin errors++; $display("FAIL zero_rv: got %0d want 1", rv_n[0] - rv0); end
  endtask

  task automatic test_sync();
    int lv0, rv0, pv0;
    do_reset();
    lv0 = lv_n[0]; rv0 = rv_n[0]; pv0 = pv_n[0];
    slot(1'b0, 32'h1111, 16, 32, 0);
    slot(1'b1, 32'h2222, 16, 32, 0);
    repeat (20) @(posedge clk);
    checks++; if (lv_n[0] != lv0) begin errors++; $display("FAIL sync_lv: got %0d want %0d", lv_n[0], lv0); end
    checks++; if (rv_n[0] != rv0) begin errors++; $display("FAIL sync_rv: got %0d want %0d", rv_n[0], rv0); end
    checks++; if (pv_n[0] != pv0) begin errors++; $display("FAIL sync_pv: got %0d want %0d", pv_n[0], pv0); end
    slot(1'b0, 32'h3333, 16, 32, 0);
    slot(1'b1, 32'h4444, 16, 32, 0);
    flush(1'b0, 0);
    checks++; if (l16 !== 16'h3333) begin errors++; $display("FAIL sync_l: got %h want 3333", l16); end
    checks++; if (r16 !== 16'h4444) begin errors++; $display("FAIL sync_r: got %h want 4444", r16); end
  endtask

  task automatic test_reset_mid();
    int lv0;
    do_reset();
    slot(1'b0, 32'h0, 16, 32, 0);
    slot(1'b1, 32'h0, 16, 32, 0);
    slot(1'b0, 32'h1357, 16, 32, 0);
    slot(1'b1, 32'h2468, 16, 32, 0);
    send_slot(1'b0, 32'hFFFF, 16, 32, 0, 9);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (l16 !== 16'h1357) begin errors++; $display("FAIL mid_pre_l: got %h want 1357", l16); end
    do_reset();
    @(negedge clk);
    checks++; if (l16 !== 16'h0) begin errors++; $display("FAIL mid_clear_l: got %h want 0000", l16); end
    lv0 = lv_n[0];
    slot(1'b1, 32'hFFFF, 16, 32, 0);
    slot(1'b0, 32'h0F0F, 16, 32, 0);
    repeat (5) @(posedge clk);
    checks++; if (lv_n[0] != lv0) begin errors++; $display("FAIL mid_no_lv: got %0d want %0d", lv_n[0], lv0); end
    slot(1'b1, 32'h0, 16, 32, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (l16 !== 16'h0F0F) begin errors++; $display("FAIL mid_l: got %h want 0f0f", l16); end
    checks++; if (lv_n[0] - lv0 != 1) begin errors++; $display("FAIL mid_lv: got %0d want 1", lv_n[0] - lv0); end
  endtask

`ifdef I2S_RX_MONO_EN
  task automatic test_mono();
    do_reset();
    slot(1'b0, 32'h0, 16, 32, 0);
    slot(1'b1, 32'h0, 16, 32, 0);
    slot(1'b0, 32'h7FFE, 16, 32, 0);
    slot(1'b1, 32'h0002, 16, 32, 0);
    flush(1'b0, 0);
    checks++; if (mono16 !== 16'h4000) begin errors++; $display("FAIL mono_pos: got %h want 4000", mono16); end
    do_reset();
    slot(1'b0, 32'h0, 16, 32, 0);
    slot(1'b1, 32'h0, 16, 32, 0);
    slot(1'b0, 32'h8000, 16, 32, 0);
    slot(1'b1, 32'h8000, 16, 32, 0);
    flush(1'b0, 0);
    checks++; if (mono16 !== 16'h8000) begin errors++; $display("FAIL mono_neg: got %h want 8000", mono16); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_format1();
    test_short_word();
    test_zero_trunc();
    test_sync();
    test_reset_mid();
`ifdef I2S_RX_MONO_EN
    test_mono();
`endif
    checks++;
    if (bad_n != 0) begin errors++; $display("FAIL strobe_shape: got %0d bad cycles want 0", bad_n); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
